// File: rtl/seq_u_bam_pkg.sv
// Shared definitions for the sequential unsigned broken-array multiplier:
// FSM state encoding and the kept-bit predicate.
package seq_u_bam_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StBusy = 2'd1;
  localparam state_t StDone = 2'd2;

  // Partial-product bit a[i]&b[j] survives unless approximate mode cuts it.
  function automatic logic bam_kept(input int unsigned i, input int unsigned j,
                                    input logic exact, input int unsigned hcut,
                                    input int unsigned vcut);
    return exact || ((j >= hcut) && ((i + j) >= vcut));
  endfunction

endpackage

// File: rtl/seq_u_bam_mul_if.sv
// Operand/result handshake bundle for seq_u_bam_mul.
interface seq_u_bam_mul_if #(
  parameter int unsigned WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_exact;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;
  logic               out_exact;

  modport master (
    output in_valid, in_a, in_b, in_exact, out_ready,
    input  in_ready, out_valid, out_p, out_exact
  );

  modport slave (
    input  in_valid, in_a, in_b, in_exact, out_ready,
    output in_ready, out_valid, out_p, out_exact
  );
endinterface

// File: rtl/bam_row_mask.sv
// One partial-product row of the broken-array multiplier: a & b[j], with the
// bits that approximate mode discards forced to zero.
module bam_row_mask
  import seq_u_bam_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned HCUT  = 4,
  parameter int unsigned VCUT  = 8,
  parameter int unsigned RowW  = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic             b_bit,
  input  logic [RowW-1:0]  j,
  input  logic             exact,
  output logic [WIDTH-1:0] row
);

  always_comb begin
    row = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      row[i] = a[i] & b_bit & bam_kept(i, 32'(j), exact, HCUT, VCUT);
    end
  end

endmodule

// File: rtl/seq_u_bam_mul.sv
// Sequential unsigned multiplier, one partial-product row per cycle, with an
// optional broken-array approximation selected per operation.
module seq_u_bam_mul
  import seq_u_bam_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned HCUT  = 4,
  parameter int unsigned VCUT  = 8
) (
  input logic             clk,
  input logic             rst,
  seq_u_bam_mul_if.slave  bus
);

  localparam int unsigned RowW = $clog2(WIDTH + 1);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("seq_u_bam_mul: WIDTH must be in 2..32");
  end
  if (HCUT > WIDTH - 1) begin : g_bad_hcut
    $error("seq_u_bam_mul: HCUT must be in 0..WIDTH-1");
  end
  if (VCUT > 2 * WIDTH - 2) begin : g_bad_vcut
    $error("seq_u_bam_mul: VCUT must be in 0..2*WIDTH-2");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               exact_q, exact_d;
  logic [RowW-1:0]    row_q, row_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic [WIDTH-1:0]   b_shift;
  logic [WIDTH-1:0]   row_bits;
  logic [2*WIDTH-1:0] row_shift;

  assign b_shift   = b_q >> row_q;
  assign row_shift = {{WIDTH{1'b0}}, row_bits} << row_q;

  bam_row_mask #(
    .WIDTH (WIDTH),
    .HCUT  (HCUT),
    .VCUT  (VCUT),
    .RowW  (RowW)
  ) u_row_mask (
    .a     (a_q),
    .b_bit (b_shift[0]),
    .j     (row_q),
    .exact (exact_q),
    .row   (row_bits)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    exact_d = exact_q;
    row_d   = row_q;
    acc_d   = acc_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          exact_d = bus.in_exact;
          acc_d   = '0;
          // Rows below HCUT contribute nothing in approximate mode, so skip them.
          row_d   = bus.in_exact ? '0 : RowW'(HCUT);
          state_d = StBusy;
        end
      end
      StBusy: begin
        acc_d = acc_q + row_shift;
        row_d = row_q + 1'b1;
        if (row_q == RowW'(WIDTH - 1)) state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      exact_q <= 1'b0;
      row_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      exact_q <= exact_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_p     = bus.out_valid ? acc_q : '0;
  assign bus.out_exact = bus.out_valid & exact_q;

endmodule

// File: doc/seq_u_bam_mul.md
SEQ_U_BAM_MUL -- requirements
Module: seq_u_bam_mul

Interface
REQ-001 Parameter WIDTH, default 8, is the operand width in bits; legal range 2..32.
REQ-002 Parameter HCUT, default 4, is the horizontal cut: rows b[j] with j < HCUT are dropped in approximate mode; legal range 0..WIDTH-1.
REQ-003 Parameter VCUT, default 8, is the vertical cut: partial-product bits of weight i+j < VCUT are dropped in approximate mode; legal range 0..2*WIDTH-2.
REQ-004 Port clk, input, 1, is the single clock; all state updates occur on its rising edge.
REQ-005 Port rst, input, 1, is the reset: synchronous, active-high.
REQ-006 Port in_valid, input, 1, indicates that an operand pair is offered.
REQ-007 Port in_ready, output, 1, indicates that the block accepts an operand pair this cycle.
REQ-008 Port in_a, input, WIDTH, is the unsigned multiplicand (index i).
REQ-009 Port in_b, input, WIDTH, is the unsigned multiplier (row index j).
REQ-010 Port in_exact, input, 1: 1 selects the exact product, 0 selects the broken-array approximation; it is sampled with the operands.
REQ-011 Port out_valid, output, 1, indicates that a result is presented.
REQ-012 Port out_ready, input, 1, indicates that the consumer takes the result.
REQ-013 Port out_p, output, 2*WIDTH, is the unsigned product.
REQ-014 Port out_exact, output, 1, echoes the captured in_exact.

Function
REQ-015 Kept bit set: in exact mode, all a[i]&b[j]; in approximate mode, only a[i]&b[j] with j >= HCUT and i+j >= VCUT.
REQ-016 out_p SHALL equal the exact sum of kept bits weighted 2^(i+j), with no truncation within 2*WIDTH bits.
REQ-017 Consequence of REQ-016: in approximate mode, out_p bits below VCUT are always 0.
REQ-018 FSM states: IDLE, BUSY, DONE.
REQ-019 IDLE: in_ready=1. On in_valid=1, capture in_a, in_b and in_exact, clear the accumulator, and go to BUSY.
REQ-020 Row pointer: on capture, the row pointer loads 0 in exact mode or HCUT in approximate mode.
REQ-021 BUSY: each cycle, add the masked row for the current row j, shifted left by j, to the accumulator, then increment the row pointer.
REQ-022 BUSY exit: after row WIDTH-1 is added, go to DONE.
REQ-023 Row count: R = WIDTH rows in exact mode, WIDTH-HCUT rows in approximate mode.
REQ-024 Latency: out_valid is first high R cycles after the accepting edge (defaults: 8 cycles exact, 4 cycles approximate).
REQ-025 DONE: out_valid=1, and out_p/out_exact are held stable until out_ready=1; on that edge, return to IDLE.
REQ-026 in_ready=0 in BUSY and DONE; in_valid in those states is ignored and not queued.
REQ-027 Throughput: at most one result per R+2 cycles; there is no overlap of operations.
REQ-028 out_p is 0 whenever out_valid=0.

Reset
REQ-029 rst=1 at a clock edge forces IDLE, clears the accumulator, operand registers and row pointer, and drives out_valid=0, out_p=0, out_exact=0, in_ready=1 on the next cycle.
REQ-030 Reset in BUSY or DONE aborts the operation; the result is discarded and never presented.
REQ-031 rst takes priority over every handshake in the same cycle.

Structure
REQ-032 Shared package seq_u_bam_pkg SHALL hold:
- the state enum (IDLE/BUSY/DONE);
- the kept-bit predicate function (i, j, exact, HCUT, VCUT).
REQ-033 One combinational sub-module, bam_row_mask, SHALL produce the WIDTH-bit masked row from a, b[j], j and exact; the top-level holds the FSM, the accumulator and the handshake.
REQ-034 An elaboration-time check SHALL reject illegal HCUT/VCUT/WIDTH values.

Verification (WIDTH=8, HCUT=4, VCUT=8)
REQ-035 Approximate full-scale: a=255, b=255, exact=0 -> out_p=60416 (0xEC00), 4 cycles after accept.
REQ-036 Exact full-scale: a=255, b=255, exact=1 -> out_p=65025 (0xFE01), 8 cycles after accept.
REQ-037 Cut boundaries, approximate mode:
- a=0x01, b=0x80 -> 0 (weight 7 < VCUT);
- a=0x80, b=0x10 -> 2048;
- a=15, b=15 -> 0.
REQ-038 Backpressure: out_ready held low 5 cycles in DONE, with in_valid pulsed -> out_p stable, in_ready=0, the pulses dropped, and exactly one result delivered.
REQ-039 Reset mid-BUSY (row 2), then a new pair a=3, b=5, exact=1 -> no stale output; out_p=15.
REQ-040 Random sweep: 10k pairs in both modes against the REQ-015/REQ-016 reference model, with random out_ready.
